// File: rtl/rv_elastic_pipe_if.sv
// Valid/ready channel shared by the elastic pipe and its neighbours.
// tx drives valid/data and samples ready; rx is the mirror image.
interface rv_if #(
  parameter int DW = 32
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport tx (output valid, output data, input ready);
  modport rx (input valid, input data, output ready);
endinterface

// File: rtl/rv_elastic_pipe.sv
// Elastic pipeline of DEPTH skid stages; ready is registered per stage, so no combinational ready path.
// Optional RV_PIPE_STATS_EN adds saturating transfer/stall counters.
//
// state | meaning
// EMPTY | main and skid empty
// BUSY  | main holds an entry, skid empty
// FULL  | main and skid hold entries, stage not ready
module rv_elastic_pipe #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  rv_if.rx                 in_ch,
  rv_if.tx                 out_ch,
  output logic [OCC_W-1:0] occupancy
`ifdef RV_PIPE_STATS_EN
  ,
  output logic [31:0]      xfer_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } stage_state_t;

  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(2*DEPTH);

  logic [DEPTH-1:0] m_v;
  logic [DEPTH-1:0] s_v;
  logic [DEPTH-1:0] vin;
  logic [DEPTH-1:0] rdy_dn;
  logic [DEPTH-1:0] push;
  logic [DEPTH-1:0] pop;
  logic [DW-1:0]    din [DEPTH];
  logic [DW-1:0]    m_d [DEPTH];

  logic in_xfer;
  logic out_xfer;

  // Flush and reset gate both handshakes so nothing moves while the pipe is being emptied.
  assign in_ch.ready  = !s_v[0] && !flush && !rst;
  assign out_ch.valid = m_v[DEPTH-1] && !flush && !rst;
  assign out_ch.data  = m_d[DEPTH-1];

  assign in_xfer  = in_ch.valid && in_ch.ready;
  assign out_xfer = out_ch.valid && out_ch.ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    stage_state_t  st_q, st_d;
    logic          ld_m_in, ld_m_skid, ld_s;
    logic [DW-1:0] md_q, sd_q;

    if (k == 0) begin : g_head
      assign vin[k] = in_ch.valid;
      assign din[k] = in_ch.data;
    end else begin : g_link
      assign vin[k] = m_v[k-1];
      assign din[k] = m_d[k-1];
    end

    if (k == DEPTH-1) begin : g_tail
      assign rdy_dn[k] = out_ch.ready;
    end else begin : g_mid
      assign rdy_dn[k] = !s_v[k+1];
    end

    assign push[k] = vin[k] && !s_v[k];
    assign pop[k]  = m_v[k] && rdy_dn[k];
    assign m_v[k]  = (st_q != EMPTY);
    assign s_v[k]  = (st_q == FULL);
    assign m_d[k]  = md_q;

    always_comb begin
      st_d      = st_q;
      ld_m_in   = 1'b0;
      ld_m_skid = 1'b0;
      ld_s      = 1'b0;
      unique case (st_q)
        EMPTY: begin
          if (push[k]) begin
            st_d    = BUSY;
            ld_m_in = 1'b1;
          end
        end
        BUSY: begin
          if (push[k] && !pop[k]) begin
            st_d = FULL;
            ld_s = 1'b1;
          end else if (pop[k] && !push[k]) begin
            st_d = EMPTY;
          end else if (push[k] && pop[k]) begin
            ld_m_in = 1'b1;
          end
        end
        FULL: begin
          if (pop[k]) begin
            st_d      = BUSY;
            ld_m_skid = 1'b1;
          end
        end
        default: st_d = EMPTY;
      endcase
      if (flush) begin
        st_d = EMPTY;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q <= EMPTY;
      end else begin
        st_q <= st_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        md_q <= '0;
        sd_q <= '0;
      end else begin
        if (ld_m_in) begin
          md_q <= din[k];
        end else if (ld_m_skid) begin
          md_q <= sd_q;
        end
        if (ld_s) begin
          sd_q <= din[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

`ifdef RV_PIPE_STATS_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_xfer && (xfer_cnt != 32'hFFFF_FFFF)) begin
        xfer_cnt <= xfer_cnt + 32'd1;
      end
      if (out_ch.valid && !out_ch.ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) occupancy <= OCC_MAX);

endmodule

// File: tb/tb_rv_elastic_pipe.sv
// Directed-vector and scoreboard bench for rv_elastic_pipe (DW=32, DEPTH=2).
module tb_rv_elastic_pipe;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(2*DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [OCC_W-1:0] occupancy;
`ifdef RV_PIPE_STATS_EN
  logic [31:0]      xfer_cnt;
  logic [31:0]      stall_cnt;
`endif

  rv_if #(.DW(DW)) in_ch ();
  rv_if #(.DW(DW)) out_ch ();

  rv_elastic_pipe #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_ch     (in_ch),
    .out_ch    (out_ch),
    .occupancy (occupancy)
`ifdef RV_PIPE_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_ch.valid  = iv;
    in_ch.data   = d;
    out_ch.ready = ordy;
    flush        = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic        chk_d;
    logic [31:0] e_od;
    int          e_occ;
  } vec_t;

  vec_t vecs[19];

  logic [31:0] q[$];

  initial begin
    // backpressure fill to 4, then drain
    vecs[0]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  0};
    vecs[1]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1};
    vecs[2]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 2};
    vecs[3]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 3};
    vecs[4]  = '{1'b1, 32'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0, 4};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0, 4};
    vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1, 3};
    vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA2, 2};
    vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA3, 1};
    vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  0};
    // three held, flush with 0x55 offered
    vecs[10] = '{1'b1, 32'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  0};
    vecs[11] = '{1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1};
    vecs[12] = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB0, 2};
    vecs[13] = '{1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  3};
    vecs[14] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  0};
    vecs[15] = '{1'b1, 32'hC0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  0};
    vecs[16] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1};
    vecs[17] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hC0, 1};
    vecs[18] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  0};

    // reset with junk offered
    rst = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_valid", out_ch.valid, 0);
      check("rst_occupancy", occupancy, 0);
      step();
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("post_rst_in_ready", in_ch.ready, 1);
    check("post_rst_out_valid", out_ch.valid, 0);
    check("post_rst_occupancy", occupancy, 0);
    check("post_rst_out_data", out_ch.data, 32'h0);
    step();

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), in_ch.ready, vecs[i].e_ir);
      check($sformatf("vec%0d_out_valid", i), out_ch.valid, vecs[i].e_ov);
      check($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].e_occ);
      if (vecs[i].chk_d) check($sformatf("vec%0d_out_data", i), out_ch.data, vecs[i].e_od);
      step();
    end

    // streaming 0x1..0x10
    begin
      int sent = 0, got = 0, first_acc = -1, first_ov = -1, last_ov = -1;
      for (int cyc = 0; cyc < 40; cyc++) begin
        drive(sent < 16, 32'(sent + 1), 1'b1, 1'b0);
        @(negedge clk);
        if (in_ch.valid) check("strm_in_ready", in_ch.ready, 1);
        check("strm_occ_le2", occupancy <= 2, 1);
        if (in_ch.valid && in_ch.ready) begin
          if (first_acc < 0) first_acc = cyc;
          sent++;
        end
        if (out_ch.valid) begin
          check("strm_data", out_ch.data, 32'(got + 1));
          got++;
          if (first_ov < 0) first_ov = cyc;
          last_ov = cyc;
        end
        step();
      end
      check("strm_count", got, 16);
      check("strm_latency", first_ov - first_acc, DEPTH);
      check("strm_rate", last_ov - first_ov, 15);
    end

    // random stress against a queue model
    begin
      int xfers = 0, cyc = 0;
      logic iv, ordy, fl, in_x, out_x;
      logic [31:0] d;
      q.delete();
      while (xfers < 10000 && cyc < 60000) begin
        fl   = ($urandom_range(99) == 0);
        iv   = 1'($urandom_range(1));
        ordy = 1'($urandom_range(1));
        d    = $urandom;
        drive(iv, d, ordy, fl);
        @(negedge clk);
        check("rnd_occupancy", occupancy, q.size());
        if (fl) begin
          check("rnd_flush_in_ready", in_ch.ready, 0);
          check("rnd_flush_out_valid", out_ch.valid, 0);
        end
        if (out_ch.valid) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rnd_spurious: out_valid=1 data=%h, model holds 0 entries", out_ch.data);
          end else begin
            check("rnd_data", out_ch.data, q[0]);
          end
        end
        in_x  = in_ch.valid && in_ch.ready;
        out_x = out_ch.valid && out_ch.ready;
        step();
        if (fl) begin
          q.delete();
        end else begin
          if (out_x && q.size() > 0) begin
            void'(q.pop_front());
            xfers++;
          end
          if (in_x) q.push_back(d);
        end
        cyc++;
      end
      check("rnd_transfers_done", xfers >= 10000, 1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    step();

    // reset mid-operation: held words must vanish
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h78, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("midrst_occupancy", occupancy, 0);
    check("midrst_in_ready", in_ch.ready, 1);
    check("midrst_out_data", out_ch.data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_out_valid", out_ch.valid, 0);
      step();
      @(negedge clk);
    end
    step();

`ifdef RV_PIPE_STATS_EN
    // 4 accepts under backpressure (3 stalled cycles), drain, then flush
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(32'hE0 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("stats_xfer_pre_flush", xfer_cnt, 4);
    check("stats_stall_pre_flush", stall_cnt, 3);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("stats_xfer_post_flush", xfer_cnt, 4);
    check("stats_stall_post_flush", stall_cnt, 3);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rv_elastic_pipe.md
Name: rv_elastic_pipe

Overview:
- Parametrised elastic pipeline of DEPTH stages carrying a DW-bit payload.
- Uses a valid/ready handshake on both sides, matching the rv_if TX/RX modport semantics.
- Successor to the fixed single-register STAGE/STAGE_EN flops. Each stage is a full-throughput skid buffer, so backpressure never creates a combinational ready path across stages.
- Used between the core, IMEM/DMEM and MMIO wherever a registered, stallable, flushable channel is needed.

Parameters:
- DW, 32, payload width in bits (>=1).
- DEPTH, 2, number of skid stages (>=1); total capacity 2*DEPTH entries.
- OCC_W, $clog2(2*DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  pipe accepts payload this cycle.
- in_data  in  DW  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts payload.
- out_data  out  DW  downstream payload.
- occupancy  out  OCC_W  number of valid entries held (0..2*DEPTH).

Behaviour:
- Reset values: all stage main/skid valids = 0; in_ready = 1 from the cycle after rst deasserts; out_valid = 0; occupancy = 0; out_data = 0. Data registers are also reset to 0.
- Handshake rules:
  - Transfer occurs when valid && ready at a posedge.
  - A producer must hold valid and data stable until the transfer. The pipe obeys this rule on its output side.
- Stage structure: stage k has a main register (m_v, m_d) and a skid register (s_v, s_d).
- Stage k ready_out = !s_v (registered, no combinational dependence on downstream ready). Stage k valid_out = m_v, data_out = m_d.
- Per-stage states and transitions (push = upstream transfer into stage, pop = downstream transfer out of stage):
  - EMPTY (m_v=0, s_v=0): push -> BUSY.
  - BUSY (m_v=1, s_v=0):
    - push && !pop -> FULL (data into skid).
    - pop && !push -> EMPTY.
    - push && pop -> BUSY (main takes new data).
  - FULL (m_v=1, s_v=1): ready_out = 0.
    - pop -> BUSY, main <= skid.
    - No push possible.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush or rst.
- Latency: an entry accepted into an empty pipe at edge N is presented on out_valid after edge N+DEPTH-1. DEPTH=1 gives out_valid the cycle after acceptance.
- Throughput: 1 transfer/cycle sustained when out_ready is held 1.
- in_ready = stage 0 !s_v. in_ready drops only after 2 entries are stalled in stage 0, which requires all downstream stages to be FULL or stalling.
- occupancy:
  - +1 on an in transfer, -1 on an out transfer, unchanged when both occur.
  - Equals the sum of all m_v and s_v. Never exceeds 2*DEPTH or underflows.
- Flush:
  - While flush=1, in_ready and out_valid are forced to 0 combinationally, so no transfers occur.
  - At that edge all m_v and s_v clear and occupancy becomes 0.
  - in_valid held during flush is not accepted.
  - Flush for multiple cycles keeps the pipe empty.
  - Flush and rst together behave as rst.
- Reset mid-operation: all entries are discarded identically to flush. Data held at that time never appears on out_data.
- Wrap/overflow: impossible by construction; an assertion checks occupancy <= 2*DEPTH.

Optional Feature:
- Macro: RV_PIPE_STATS_EN.
- When defined, the block adds two outputs:
  - xfer_cnt [31:0]: count of out transfers.
  - stall_cnt [31:0]: cycles with out_valid=1 && out_ready=0.
- Both counters saturate at 32'hFFFF_FFFF, clear on rst, and are not cleared by flush.
- When undefined, the ports and counters are absent and the block is otherwise identical.

Test Plan:
- Reset: rst=1 for 3 cycles with in_valid=1, in_data=32'hDEAD_BEEF -> during and after reset out_valid=0 and occupancy=0; in_ready=1 in the first cycle after rst drops.
- Streaming (DW=32, DEPTH=2): out_ready=1, push 32'h1..32'h10 back-to-back -> in_ready stays 1; first out_valid 1 cycle after the first accept; then 1 word/cycle in order 0x1..0x10; occupancy never exceeds 2.
- Backpressure fill: out_ready=0, push 32'hA0,A1,... -> exactly 4 accepted (A0..A3); in_ready=0; occupancy=4; out_data=A0 held stable. Then out_ready=1 -> A0..A3 emerge in order, in_ready returns to 1 within DEPTH cycles.
- Flush: 3 entries held with out_ready=0, pulse flush for 1 cycle with in_valid=1, in_data=32'h55 -> during flush in_ready=0 and out_valid=0; next cycle occupancy=0; 0x55 and the flushed words never appear.
- Random stress: 10000 transfers with random in_valid/out_ready (50%) and 1% flush pulses vs a scoreboard model -> zero ordering or data mismatches, and occupancy matches the model every cycle.
- Stats (RV_PIPE_STATS_EN): 4 transfers with 3 stalled cycles interleaved, then flush -> xfer_cnt=4 and stall_cnt=3, both unchanged by the flush.
